// File: rtl/spk_out_pkg.sv
// Shared definitions for the spike-out path: packet layout and neuron ID field helpers.
// The work controller imports the same package, so both sides agree on the {z,y,x} layout.
package spk_out_pkg;

  localparam int unsigned SPK_SW = 24;
  localparam int unsigned SPK_DW = 8;

  // Packet is {dst_y, dst_x, neuid}; offsets below are for the default widths.
  localparam int unsigned NEUID_LSB = 0;
  localparam int unsigned DSTX_LSB  = SPK_SW;
  localparam int unsigned DSTY_LSB  = SPK_SW + SPK_DW;

  function automatic int unsigned dstx_lsb(input int unsigned sw);
    return sw;
  endfunction

  function automatic int unsigned dsty_lsb(input int unsigned sw, input int unsigned dw);
    return sw + dw;
  endfunction

  function automatic int unsigned pkt_width(input int unsigned sw, input int unsigned dw);
    return 2 * dw + sw;
  endfunction

  typedef logic [SPK_SW-1:0]   neuid_t;
  typedef logic [SPK_SW/3-1:0] neu_coord_t;

  function automatic neu_coord_t neuid_x(input neuid_t id);
    return id[SPK_SW/3-1:0];
  endfunction

  function automatic neu_coord_t neuid_y(input neuid_t id);
    return id[2*SPK_SW/3-1:SPK_SW/3];
  endfunction

  function automatic neu_coord_t neuid_z(input neuid_t id);
    return id[SPK_SW-1:2*SPK_SW/3];
  endfunction

endpackage

// File: rtl/spk_fifo.sv
// Circular buffer for spike packets; the caller must only push when not full or when popping.
// Read data is the registered head entry, addressed by the registered read pointer.
module spk_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 16,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic [Aw:0]      count_nxt,
  output logic             full,
  output logic             empty
);

  localparam logic [Aw:0] DepthCnt = (Aw+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      count_q, count_d;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign count_nxt = count_d;
  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/spk_out.sv
// Spike output stage: buffers fired neuron IDs tagged with destination offsets and
// streams them to the router over valid/ready, with almost-full back-pressure and drop count.
module spk_out
  import spk_out_pkg::*;
#(
  parameter int unsigned SW          = 24,
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned FULL_MARGIN = 4,
  parameter int unsigned CW          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soma_spk_vld,
  input  logic                 soma_spk_fire,
  input  logic [SW-1:0]        config_spk_out_neuid,
  output logic                 spk_out_config_full,
  input  logic [DW-1:0]        dst_x,
  input  logic [DW-1:0]        dst_y,
  output logic                 spk_out_vld,
  output logic [2*DW+SW-1:0]   spk_out_data,
  input  logic                 spk_out_rdy,
  output logic                 spk_out_empty,
  output logic [CW-1:0]        drop_cnt,
  input  logic                 drop_clr
);

  localparam int unsigned PW      = pkt_width(SW, DW);
  localparam int unsigned XLsb    = dstx_lsb(SW);
  localparam int unsigned YLsb    = dsty_lsb(SW, DW);
  localparam logic [AW:0] FullThr = (AW+1)'(DEPTH - FULL_MARGIN);

  logic          fire, push, pop, drop;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   count_nxt;
  logic [PW-1:0] push_data, head_data;

  logic          vld_q;
  logic [PW-1:0] data_q;
  logic          full_q;
  logic [CW-1:0] drop_q;

  always_comb begin
    push_data = '0;
    push_data[NEUID_LSB +: SW] = config_spk_out_neuid;
    push_data[XLsb +: DW]      = dst_x;
    push_data[YLsb +: DW]      = dst_y;
  end

  assign fire = soma_spk_vld && soma_spk_fire;
  assign pop  = !fifo_empty && (!vld_q || spk_out_rdy);
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push = fire && (!fifo_full || pop);
  assign drop = fire && fifo_full && !pop;

  spk_fifo #(
    .Width(PW),
    .Depth(DEPTH),
    .Aw   (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wdata    (push_data),
    .rdata    (head_data),
    .count_nxt(count_nxt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (pop) begin
      vld_q  <= 1'b1;
      data_q <= head_data;
    end else if (spk_out_rdy) begin
      vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= (count_nxt >= FullThr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_clr) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign spk_out_vld         = vld_q;
  assign spk_out_data        = data_q;
  assign spk_out_config_full = full_q;
  assign spk_out_empty       = fifo_empty && !vld_q;
  assign drop_cnt            = drop_q;

endmodule

// File: tb/tb_spk_out.sv
// Directed bench for spk_out: a cycle vector table for the basic path plus hand sequences
// for back-pressure, overflow, push/pop at full, asynchronous reset and drop clear.
module tb_spk_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        soma_spk_vld, soma_spk_fire;
  logic [23:0] config_spk_out_neuid;
  logic        spk_out_config_full;
  logic [7:0]  dst_x, dst_y;
  logic        spk_out_vld;
  logic [39:0] spk_out_data;
  logic        spk_out_rdy;
  logic        spk_out_empty;
  logic [15:0] drop_cnt;
  logic        drop_clr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spk_out dut (
    .clk                 (clk),
    .rst                 (rst),
    .soma_spk_vld        (soma_spk_vld),
    .soma_spk_fire       (soma_spk_fire),
    .config_spk_out_neuid(config_spk_out_neuid),
    .spk_out_config_full (spk_out_config_full),
    .dst_x               (dst_x),
    .dst_y               (dst_y),
    .spk_out_vld         (spk_out_vld),
    .spk_out_data        (spk_out_data),
    .spk_out_rdy         (spk_out_rdy),
    .spk_out_empty       (spk_out_empty),
    .drop_cnt            (drop_cnt),
    .drop_clr            (drop_clr)
  );

  typedef struct {
    bit          sv;
    bit          sf;
    logic [23:0] nid;
    bit          rdy;
    bit          clr;
    bit          ev;
    logic [39:0] ed;
    bit          ef;
    bit          ee;
    logic [15:0] edrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sv, bit sf, logic [23:0] nid, bit ev, logic [39:0] ed,
                              bit ee);
    vec_t v;
    v.sv = sv; v.sf = sf; v.nid = nid; v.rdy = 1'b1; v.clr = 1'b0;
    v.ev = ev; v.ed = ed; v.ef = 1'b0; v.ee = ee; v.edrop = 16'd0;
    return v;
  endfunction

  function automatic logic [39:0] pkt(input logic [23:0] nid);
    return {8'd5, 8'd3, nid};
  endfunction

  function automatic logic [23:0] sid(input int i);
    return 24'h100000 + 24'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sv, input bit sf, input logic [23:0] nid, input bit rdy,
                       input bit clr);
    soma_spk_vld = sv; soma_spk_fire = sf; config_spk_out_neuid = nid;
    spk_out_rdy = rdy; drop_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 24'h0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    dst_x = 8'd3;
    dst_y = 8'd5;
    rst   = 1'b1;
    drive(0, 0, 24'h0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.vld",   64'(spk_out_vld), 64'd0);
    chk("rst.data",  64'(spk_out_data), 64'd0);
    chk("rst.full",  64'(spk_out_config_full), 64'd0);
    chk("rst.empty", 64'(spk_out_empty), 64'd1);
    chk("rst.drop",  64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // Single spike, then two back-to-back, then non-firing results.
    vecs.push_back(mk(0, 0, 24'h0,      0, 40'h0,           1));
    vecs.push_back(mk(1, 1, 24'h010203, 0, 40'h0,           1));
    vecs.push_back(mk(0, 0, 24'h0,      0, 40'h0,           0));
    vecs.push_back(mk(0, 0, 24'h0,      1, 40'h0503010203,  0));
    vecs.push_back(mk(0, 0, 24'h0,      0, 40'h0,           1));
    vecs.push_back(mk(1, 1, 24'h0A0B0C, 0, 40'h0,           1));
    vecs.push_back(mk(1, 1, 24'h112233, 0, 40'h0,           0));
    vecs.push_back(mk(0, 0, 24'h0,      1, 40'h05030A0B0C,  0));
    vecs.push_back(mk(0, 0, 24'h0,      1, 40'h0503112233,  0));
    vecs.push_back(mk(0, 0, 24'h0,      0, 40'h0,           1));
    for (int i = 0; i < 20; i++) vecs.push_back(mk(1, 0, 24'(i * 7 + 1), 0, 40'h0, 1));
    vecs.push_back(mk(0, 0, 24'h0,      0, 40'h0,           1));
    vecs.push_back(mk(0, 0, 24'h0,      0, 40'h0,           1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].sv, vecs[i].sf, vecs[i].nid, vecs[i].rdy, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d.vld", i),   64'(spk_out_vld), 64'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d.data", i), 64'(spk_out_data), 64'(vecs[i].ed));
      chk($sformatf("vec%0d.full", i),  64'(spk_out_config_full), 64'(vecs[i].ef));
      chk($sformatf("vec%0d.empty", i), 64'(spk_out_empty), 64'(vecs[i].ee));
      chk($sformatf("vec%0d.drop", i),  64'(drop_cnt), 64'(vecs[i].edrop));
    end

    // Back-pressure: spike 0 sits in the output register, 16 more fill the FIFO.
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i <= 16; i++) begin
      drive(1, 1, sid(i), 0, 0);
      step();
      chk($sformatf("bp%0d.full", i), 64'(spk_out_config_full), 64'(i >= 12));
      chk($sformatf("bp%0d.vld", i),  64'(spk_out_vld), 64'(i >= 1));
      if (i >= 1) chk($sformatf("bp%0d.data", i), 64'(spk_out_data), 64'(pkt(sid(0))));
    end
    for (int i = 17; i <= 19; i++) begin
      drive(1, 1, sid(i), 0, 0);
      step();
      chk($sformatf("ovf%0d.drop", i), 64'(drop_cnt), 64'(i - 16));
      chk($sformatf("ovf%0d.data", i), 64'(spk_out_data), 64'(pkt(sid(0))));
    end

    // Fire while the router takes spike 0: push accepted despite the full FIFO.
    drive(1, 1, sid(20), 1, 0);
    step();
    chk("pp.vld",  64'(spk_out_vld), 64'd1);
    chk("pp.data", 64'(spk_out_data), 64'(pkt(sid(1))));
    chk("pp.drop", 64'(drop_cnt), 64'd3);
    chk("pp.full", 64'(spk_out_config_full), 64'd1);
    drive(0, 0, 24'h0, 1, 0);
    for (int j = 2; j <= 17; j++) begin
      step();
      chk($sformatf("drain%0d.vld", j),  64'(spk_out_vld), 64'd1);
      chk($sformatf("drain%0d.data", j), 64'(spk_out_data),
          64'(pkt(j <= 16 ? sid(j) : sid(20))));
    end
    step();
    chk("drain.end.vld",   64'(spk_out_vld), 64'd0);
    chk("drain.end.empty", 64'(spk_out_empty), 64'd1);
    chk("drain.end.full",  64'(spk_out_config_full), 64'd0);
    chk("drain.end.drop",  64'(drop_cnt), 64'd3);

    // Asynchronous reset with spikes buffered and a packet presented.
    drive(0, 0, 24'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, sid(30 + i), 0, 0);
      step();
    end
    drive(0, 0, 24'h0, 0, 0);
    step();
    chk("prerst.vld",   64'(spk_out_vld), 64'd1);
    chk("prerst.empty", 64'(spk_out_empty), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.vld",   64'(spk_out_vld), 64'd0);
    chk("arst.empty", 64'(spk_out_empty), 64'd1);
    chk("arst.data",  64'(spk_out_data), 64'd0);
    chk("arst.drop",  64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 24'h0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("postrst%0d.vld", i),   64'(spk_out_vld), 64'd0);
      chk($sformatf("postrst%0d.empty", i), 64'(spk_out_empty), 64'd1);
    end

    // Drop clear wins over a same-cycle drop.
    for (int i = 0; i <= 16; i++) begin
      drive(1, 1, sid(40 + i), 0, 0);
      step();
    end
    drive(1, 1, sid(60), 0, 0);
    step();
    chk("clr.pre.drop", 64'(drop_cnt), 64'd1);
    drive(1, 1, sid(61), 0, 1);
    step();
    chk("clr.drop", 64'(drop_cnt), 64'd0);
    drive(0, 0, 24'h0, 0, 0);
    step();
    chk("clr.hold", 64'(drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spk_out.md
Name: spk_out

Overview:
- Receiving end of the work-controller spike interface.
- The work controller scans neurons and presents a registered neuron ID `{z,y,x}` on `config_spk_out_neuid`; the soma reports fire/no-fire for the same neuron in the same cycle.
- spk_out stores fired neuron IDs in a FIFO and tags each with its destination offsets. It emits them as packets to the node router over a valid/ready link.
- It back-pressures the work controller through `spk_out_config_full`.

Parameters:
- SW, 24, neuron ID width, packed `{z,y,x}`, SW/3 bits each
- DW, 8, destination offset width per axis
- DEPTH, 16, FIFO entries; power of 2, minimum 8
- AW, 4, log2(DEPTH)
- FULL_MARGIN, 4, free entries reserved for in-flight spikes; range 3 to DEPTH-1
- CW, 16, drop counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- soma_spk_vld  in  1  soma result valid for the current `config_spk_out_neuid`
- soma_spk_fire  in  1  neuron fired; meaningful only with `soma_spk_vld`
- config_spk_out_neuid  in  SW  neuron ID from the work controller
- spk_out_config_full  out  1  almost-full back-pressure to the work controller
- dst_x  in  DW  static x hop offset; software-stable while busy
- dst_y  in  DW  static y hop offset; software-stable while busy
- spk_out_vld  out  1  packet valid to router
- spk_out_data  out  2*DW+SW  packet `{dst_y, dst_x, neuid}`
- spk_out_rdy  in  1  router accepts the packet
- spk_out_empty  out  1  no spike buffered or pending
- drop_cnt  out  CW  saturating count of dropped spikes
- drop_clr  in  1  synchronous clear of `drop_cnt`

Behaviour:
- Reset:
  - FIFO pointers and count are 0.
  - `spk_out_vld`=0, `spk_out_data`=0, `spk_out_config_full`=0, `spk_out_empty`=1, `drop_cnt`=0.
  - Reset asserted mid-operation discards all buffered and pending spikes immediately (asynchronous).
- Push:
  - Occurs in a cycle where `soma_spk_vld` && `soma_spk_fire`.
  - Entry written = `{dst_y, dst_x, config_spk_out_neuid}`, sampled that cycle.
  - `soma_spk_vld` with `soma_spk_fire`=0 writes nothing.
- Pop:
  - Occurs when the FIFO is non-empty and the output register is free (`!spk_out_vld` || `spk_out_rdy`).
  - The head entry loads into the output register at that edge; `spk_out_vld`=1 the next cycle.
- Latency:
  - For a spike pushed at edge N into an empty FIFO with the output free, `spk_out_vld` rises in cycle N+2.
  - Sustained throughput is 1 packet/cycle while `spk_out_rdy`=1.
- Handshake:
  - A transfer occurs on `spk_out_vld` && `spk_out_rdy`.
  - While `spk_out_vld`=1 and `spk_out_rdy`=0, `spk_out_data` is held stable.
  - `spk_out_vld` never deasserts without a transfer.
- Count update: count += push − pop. Simultaneous push and pop leaves count unchanged.
- Full flag:
  - `spk_out_config_full` is registered; it is 1 when the next count ≥ DEPTH−FULL_MARGIN, otherwise 0.
  - FULL_MARGIN covers the work controller's reaction latency (at most 3 pushes after assertion).
- Overflow:
  - A push when count==DEPTH and no pop in the same cycle is dropped.
  - On a drop, `drop_cnt` increments and saturates at all-ones.
  - If a pop occurs in the same cycle, the push is accepted.
- Drop clear: `drop_clr` clears `drop_cnt` and takes priority over a same-cycle increment.
- Empty: `spk_out_empty` = (count==0) && !`spk_out_vld`. It is combinational from registers.
- Pointers are AW bits and wrap naturally at DEPTH. Count is AW+1 bits.

Decomposition:
- Shared package holds:
  - packet field offsets: NEUID_LSB=0, DSTX_LSB=SW, DSTY_LSB=SW+DW
  - packet width function 2*DW+SW
  - neuron ID field slicing helpers `{z,y,x}`, shared with the work controller
- One sub-module, `spk_fifo`:
  - synchronous-write, registered-read circular buffer, DEPTH×(2*DW+SW)
  - push/pop/count/full/empty interface
- The top level holds the output register, almost-full logic and drop counter.

Test Plan:
- Single spike:
  - Stimulus: dst_x=3, dst_y=5, neuid=0x010203, fire at cycle 10, `spk_out_rdy`=1.
  - Required: `spk_out_vld` in cycle 12 only, data=0x05_03_010203; `spk_out_empty` returns to 1 in cycle 13.
- Non-firing results:
  - Stimulus: 20 cycles of `soma_spk_vld`=1 with `soma_spk_fire`=0.
  - Required: no packets, count stays 0.
- Back-pressure and full flag:
  - Stimulus: `spk_out_rdy`=0, then one spike per cycle.
  - Required: `spk_out_config_full` rises the cycle after the 12th buffered entry (DEPTH=16, FULL_MARGIN=4); `spk_out_data` stays on spike 0 throughout.
- Overflow:
  - Stimulus: `spk_out_rdy`=0 with 17 buffered spikes plus 3 further pushes.
  - Required: `drop_cnt`=3; after `spk_out_rdy`=1, the stored spikes drain in order with no gaps.
- Push and pop at full:
  - Stimulus: count=16 with simultaneous fire and transfer.
  - Required: push accepted, `drop_cnt` unchanged, count=16.
- Reset and clear:
  - Stimulus: assert `rst` with 5 spikes buffered and `spk_out_vld`=1.
  - Required: `spk_out_vld`=0 and `spk_out_empty`=1 immediately; no stale packet after release.
  - Stimulus: `drop_clr` in the same cycle as a drop.
  - Required: `drop_cnt`=0.
